// File: rtl/e203_csr_pkg.sv
// Shared constants for the EXU trap-state CSR file.
package e203_csr_pkg;

  localparam int unsigned CSR_IDX_W = 12;

  // CSR addresses
  localparam logic [CSR_IDX_W-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_IDX_W-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_IDX_W-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_IDX_W-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [CSR_IDX_W-1:0] CSR_MTVAL   = 12'h343;
  localparam logic [CSR_IDX_W-1:0] CSR_DCSR    = 12'h7B0;
  localparam logic [CSR_IDX_W-1:0] CSR_DPC     = 12'h7B1;

  // mstatus field positions
  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;
  localparam logic [1:0]  MSTATUS_MPP_VAL = 2'b11;

  // mcause: interrupt flag plus a 5-bit exception code
  localparam int unsigned MCAUSE_CODE_W = 5;

  // dcsr layout
  localparam int unsigned DCAUSE_W       = 3;
  localparam int unsigned DCSR_DCAUSE_LO = 6;
  localparam int unsigned DCSR_VER_W     = 4;
  localparam logic [3:0]  DCSR_XDEBUGVER = 4'h4;
  localparam logic [1:0]  DCSR_PRV       = 2'b11;

  typedef enum logic [DCAUSE_W-1:0] {
    DCAUSE_NONE    = 3'd0,
    DCAUSE_EBREAK  = 3'd1,
    DCAUSE_TRIGGER = 3'd2,
    DCAUSE_HALTREQ = 3'd3,
    DCAUSE_STEP    = 3'd4,
    DCAUSE_HALT    = 3'd5
  } dcause_e;

  // dcsr/dpc are only reachable while the core is in debug mode
  function automatic logic is_dbg_csr(input logic [CSR_IDX_W-1:0] idx);
    return (idx == CSR_DCSR) || (idx == CSR_DPC);
  endfunction

endpackage

// File: rtl/e203_trap_csr_reg.sv
// Width-parametrised enable flop with synchronous active-low reset.
module e203_trap_csr_reg #(
  parameter int unsigned W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset dominates; otherwise load on enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (ena) begin
      q <= d;
    end
  end

endmodule

// File: rtl/e203_exu_trap_csr.sv
// Trap-state CSRs (mstatus/mtvec/mepc/mcause/mtval/dcsr/dpc) and debug-mode flag.
module e203_exu_trap_csr
  import e203_csr_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PC_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmt_epc_ena,
  input  logic                 cmt_cause_ena,
  input  logic                 cmt_badaddr_ena,
  input  logic                 cmt_status_ena,
  input  logic [PC_SIZE-1:0]   cmt_epc,
  input  logic [XLEN-1:0]      cmt_cause,
  input  logic [XLEN-1:0]      cmt_badaddr,
  input  logic                 cmt_dpc_ena,
  input  logic [PC_SIZE-1:0]   cmt_dpc,
  input  logic                 cmt_dcause_ena,
  input  logic [DCAUSE_W-1:0]  cmt_dcause,
  input  logic                 cmt_mret_ena,
  input  logic                 cmt_dret_ena,
  input  logic                 csr_ena,
  input  logic                 csr_wr_en,
  input  logic                 csr_rd_en,
  input  logic [CSR_IDX_W-1:0] csr_idx,
  input  logic [XLEN-1:0]      wbck_csr_dat,
  output logic [XLEN-1:0]      read_csr_dat,
  output logic                 csr_access_ilgl,
  output logic [PC_SIZE-1:0]   csr_mtvec_r,
  output logic [PC_SIZE-1:0]   csr_mepc_r,
  output logic [PC_SIZE-1:0]   csr_dpc_r,
  output logic                 status_mie_r,
  output logic                 dbg_mode
);

  logic                     csr_wr;
  logic [PC_SIZE-1:0]       wdat_pc;
  logic                     wr_mstatus, wr_mtvec, wr_mepc, wr_mcause, wr_mtval, wr_dpc;

  logic                     mpie_r;
  logic                     mcause_irq_r;
  logic [MCAUSE_CODE_W-1:0] mcause_code_r;
  logic [XLEN-1:0]          mtval_r;
  logic [DCAUSE_W-1:0]      dcause_r;

  logic                     mie_ena, mie_nxt, mpie_nxt;
  logic                     mepc_ena, mcause_ena, mtval_ena, dpc_ena, dbg_ena;
  logic [PC_SIZE-1:0]       mtvec_nxt, mepc_nxt, dpc_nxt;
  logic                     mcause_irq_nxt;
  logic [MCAUSE_CODE_W-1:0] mcause_code_nxt;
  logic [XLEN-1:0]          mtval_nxt;

  logic                     unused_bits;

  assign csr_wr  = csr_ena & csr_wr_en;
  assign wdat_pc = PC_SIZE'(wbck_csr_dat);

  // Decode the CSR write target; debug CSRs are write-protected outside debug mode
  always_comb begin
    wr_mstatus = 1'b0;
    wr_mtvec   = 1'b0;
    wr_mepc    = 1'b0;
    wr_mcause  = 1'b0;
    wr_mtval   = 1'b0;
    wr_dpc     = 1'b0;
    if (csr_wr) begin
      case (csr_idx)
        CSR_MSTATUS: wr_mstatus = 1'b1;
        CSR_MTVEC:   wr_mtvec   = 1'b1;
        CSR_MEPC:    wr_mepc    = 1'b1;
        CSR_MCAUSE:  wr_mcause  = 1'b1;
        CSR_MTVAL:   wr_mtval   = 1'b1;
        CSR_DPC:     wr_dpc     = dbg_mode;
        default:     ;
      endcase
    end
  end

  // Next-value muxes: commit strobes take precedence over a colliding CSR write
  always_comb begin
    mie_ena  = cmt_status_ena | cmt_mret_ena | wr_mstatus;
    mie_nxt  = wbck_csr_dat[MSTATUS_MIE];
    mpie_nxt = wbck_csr_dat[MSTATUS_MPIE];
    if (cmt_status_ena) begin
      mie_nxt  = 1'b0;
      mpie_nxt = status_mie_r;
    end else if (cmt_mret_ena) begin
      mie_nxt  = mpie_r;
      mpie_nxt = 1'b1;
    end

    mtvec_nxt = {wdat_pc[PC_SIZE-1:2], 2'b00};

    mepc_ena = cmt_epc_ena | wr_mepc;
    mepc_nxt = cmt_epc_ena ? {cmt_epc[PC_SIZE-1:1], 1'b0} : {wdat_pc[PC_SIZE-1:1], 1'b0};

    mcause_ena      = cmt_cause_ena | wr_mcause;
    mcause_irq_nxt  = cmt_cause_ena ? cmt_cause[XLEN-1] : wbck_csr_dat[XLEN-1];
    mcause_code_nxt = cmt_cause_ena ? cmt_cause[MCAUSE_CODE_W-1:0]
                                    : wbck_csr_dat[MCAUSE_CODE_W-1:0];

    mtval_ena = cmt_badaddr_ena | wr_mtval;
    mtval_nxt = cmt_badaddr_ena ? cmt_badaddr : wbck_csr_dat;

    dpc_ena = cmt_dpc_ena | wr_dpc;
    dpc_nxt = cmt_dpc_ena ? {cmt_dpc[PC_SIZE-1:1], 1'b0} : {wdat_pc[PC_SIZE-1:1], 1'b0};

    // Debug entry wins over a simultaneous dret
    dbg_ena = cmt_dpc_ena | cmt_dret_ena;
  end

  e203_trap_csr_reg #(.W(1)) u_mie (
    .clk(clk), .rst_n(rst_n), .ena(mie_ena), .d(mie_nxt), .q(status_mie_r)
  );

  e203_trap_csr_reg #(.W(1)) u_mpie (
    .clk(clk), .rst_n(rst_n), .ena(mie_ena), .d(mpie_nxt), .q(mpie_r)
  );

  e203_trap_csr_reg #(.W(PC_SIZE)) u_mtvec (
    .clk(clk), .rst_n(rst_n), .ena(wr_mtvec), .d(mtvec_nxt), .q(csr_mtvec_r)
  );

  e203_trap_csr_reg #(.W(PC_SIZE)) u_mepc (
    .clk(clk), .rst_n(rst_n), .ena(mepc_ena), .d(mepc_nxt), .q(csr_mepc_r)
  );

  e203_trap_csr_reg #(.W(1)) u_mcause_irq (
    .clk(clk), .rst_n(rst_n), .ena(mcause_ena), .d(mcause_irq_nxt), .q(mcause_irq_r)
  );

  e203_trap_csr_reg #(.W(MCAUSE_CODE_W)) u_mcause_code (
    .clk(clk), .rst_n(rst_n), .ena(mcause_ena), .d(mcause_code_nxt), .q(mcause_code_r)
  );

  e203_trap_csr_reg #(.W(XLEN)) u_mtval (
    .clk(clk), .rst_n(rst_n), .ena(mtval_ena), .d(mtval_nxt), .q(mtval_r)
  );

  e203_trap_csr_reg #(.W(PC_SIZE)) u_dpc (
    .clk(clk), .rst_n(rst_n), .ena(dpc_ena), .d(dpc_nxt), .q(csr_dpc_r)
  );

  e203_trap_csr_reg #(.W(DCAUSE_W)) u_dcause (
    .clk(clk), .rst_n(rst_n), .ena(cmt_dcause_ena), .d(cmt_dcause), .q(dcause_r)
  );

  e203_trap_csr_reg #(.W(1)) u_dbg_mode (
    .clk(clk), .rst_n(rst_n), .ena(dbg_ena), .d(cmt_dpc_ena), .q(dbg_mode)
  );

  // Illegal access: debug CSR touched while not in debug mode
  assign csr_access_ilgl = csr_ena & is_dbg_csr(csr_idx) & ~dbg_mode;

  // Combinational read mux from current state
  always_comb begin
    read_csr_dat = '0;
    case (csr_idx)
      CSR_MSTATUS: begin
        read_csr_dat[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MSTATUS_MPP_VAL;
        read_csr_dat[MSTATUS_MPIE]                  = mpie_r;
        read_csr_dat[MSTATUS_MIE]                   = status_mie_r;
      end
      CSR_MTVEC:  read_csr_dat = XLEN'(csr_mtvec_r);
      CSR_MEPC:   read_csr_dat = XLEN'(csr_mepc_r);
      CSR_MCAUSE: begin
        read_csr_dat[XLEN-1]              = mcause_irq_r;
        read_csr_dat[MCAUSE_CODE_W-1:0]   = mcause_code_r;
      end
      CSR_MTVAL:  read_csr_dat = mtval_r;
      CSR_DCSR: begin
        if (dbg_mode) begin
          read_csr_dat[XLEN-1 -: DCSR_VER_W]          = DCSR_XDEBUGVER;
          read_csr_dat[DCSR_DCAUSE_LO +: DCAUSE_W]    = dcause_r;
          read_csr_dat[1:0]                           = DCSR_PRV;
        end
      end
      CSR_DPC: begin
        if (dbg_mode) read_csr_dat = XLEN'(csr_dpc_r);
      end
      default: ;
    endcase
  end

  // Inputs or bits that carry no state in this block
  assign unused_bits = ^{csr_rd_en, cmt_cause, cmt_epc[0], cmt_dpc[0], wdat_pc[0]};

endmodule
